div_unit: RTL and testbench

- Iterative radix-2 restoring divider for MIPS DIV/DIVU in the EXE stage.
- Its quotient and remainder are written to HI/LO and feed the EXE result-select mux.
- busy drives the pipeline stall logic.
- Produces one result per WIDTH-cycle operation.
- Supports flush for exceptions and branch squash.

---
 rtl/div_unit.sv | 216 +++++++++++++++++++++
 tb/tb_div_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
//
// Iterative radix-2 restoring divider for MIPS DIV/DIVU in the EXE stage.
// One quotient bit is produced per clock. A full operation with a nonzero
// divisor takes WIDTH RUN cycles. A zero divisor skips RUN and goes
// straight to DONE with the architectural divide-by-zero result.
// The quotient goes to LO and the remainder goes to HI.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   start      request a new division (accepted in IDLE or DONE)
//   flush      synchronous abort; has priority over start
//   is_signed  1 = DIV (two's complement), 0 = DIVU
//   dividend   numerator, sampled with start
//   divisor    denominator, sampled with start
//   busy       high while iterating (pipeline stall request)
//   valid      one-cycle pulse; quotient/remainder hold a new result
//   quotient   result to LO; held between results
//   remainder  result to HI; held between results
// -----------------------------------------------------------------------------
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             flush,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int               CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]    CNT_ONE  = CW'(32'd1);
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] W_ZERO   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] W_ONES   = {WIDTH{1'b1}};
    localparam logic [WIDTH:0]   R_ZERO   = {(WIDTH+1){1'b0}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Two's complement negation.
    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Unsigned magnitude of an operand. The most negative value maps onto
    // itself, which reads correctly as 2^(WIDTH-1) in unsigned form.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             sgn);
        if (sgn && v[WIDTH-1]) begin
            return negate(v);
        end else begin
            return v;
        end
    endfunction

    state_t           state_r;
    state_t           state_next_s;
    logic [CW-1:0]    count_r;
    logic [WIDTH:0]   rem_r;       // partial remainder
    logic [WIDTH-1:0] work_r;      // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] dvsr_r;      // divisor magnitude
    logic             neg_q_r;
    logic             neg_r_r;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;

    logic             divisor_zero_s;
    logic             can_accept_s;
    logic             accept_s;
    logic             last_s;
    logic [WIDTH+1:0] shifted_s;
    logic [WIDTH+1:0] trial_s;
    logic             fits_s;
    logic [WIDTH:0]   rem_next_s;
    logic [WIDTH-1:0] work_next_s;
    logic [WIDTH-1:0] q_final_s;
    logic [WIDTH-1:0] r_final_s;

    assign divisor_zero_s = (divisor == W_ZERO);
    assign can_accept_s   = (state_r == S_IDLE) || (state_r == S_DONE);
    assign accept_s       = can_accept_s && start && !flush;
    assign last_s         = (state_r == S_RUN) && (count_r == CNT_LAST);

    // One restoring step. The partial remainder is always below the
    // divisor, so the shifted value is below 2^(WIDTH+1). A WIDTH+2 bit
    // difference therefore has its top bit set exactly when the trial
    // subtraction goes negative.
    always_comb begin
        shifted_s   = {rem_r, work_r[WIDTH-1]};
        trial_s     = shifted_s - {2'b00, dvsr_r};
        fits_s      = ~trial_s[WIDTH+1];
        rem_next_s  = R_ZERO;
        if (fits_s) begin
            rem_next_s = trial_s[WIDTH:0];
        end else begin
            rem_next_s = shifted_s[WIDTH:0];
        end
        work_next_s = {work_r[WIDTH-2:0], fits_s};
    end

    // Sign correction applied to the last iteration's magnitudes. The
    // -2^(WIDTH-1) / -1 case needs no special case: 2^(WIDTH-1) / 1 with
    // matching signs leaves the quotient bit pattern as 0x80..0.
    always_comb begin
        q_final_s = work_next_s;
        r_final_s = rem_next_s[WIDTH-1:0];
        if (neg_q_r) begin
            q_final_s = negate(work_next_s);
        end else begin
            q_final_s = work_next_s;
        end
        if (neg_r_r) begin
            r_final_s = negate(rem_next_s[WIDTH-1:0]);
        end else begin
            r_final_s = rem_next_s[WIDTH-1:0];
        end
    end

    // Next-state logic. Flush wins over everything, including a
    // back-to-back start presented in DONE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE, S_DONE: begin
                if (flush) begin
                    state_next_s = S_IDLE;
                end else if (start) begin
                    if (divisor_zero_s) begin
                        state_next_s = S_DONE;
                    end else begin
                        state_next_s = S_RUN;
                    end
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_next_s = S_IDLE;
                end else if (last_s) begin
                    state_next_s = S_DONE;
                end else begin
                    state_next_s = S_RUN;
                end
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand capture, iteration datapath and result registers. The
    // results load only on the edge entering DONE. A flush leaves them
    // untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r     <= CNT_ZERO;
            rem_r       <= R_ZERO;
            work_r      <= W_ZERO;
            dvsr_r      <= W_ZERO;
            neg_q_r     <= 1'b0;
            neg_r_r     <= 1'b0;
            quotient_r  <= W_ZERO;
            remainder_r <= W_ZERO;
        end else if (flush) begin
            count_r <= CNT_ZERO;
        end else if (accept_s) begin
            count_r <= CNT_ZERO;
            rem_r   <= R_ZERO;
            work_r  <= magnitude(dividend, is_signed);
            dvsr_r  <= magnitude(divisor, is_signed);
            neg_q_r <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r_r <= is_signed && dividend[WIDTH-1];
            if (divisor_zero_s) begin
                quotient_r  <= W_ONES;
                remainder_r <= dividend;
            end
        end else if (state_r == S_RUN) begin
            rem_r   <= rem_next_s;
            work_r  <= work_next_s;
            count_r <= count_r + CNT_ONE;
            if (last_s) begin
                quotient_r  <= q_final_s;
                remainder_r <= r_final_s;
            end
        end
    end

    assign busy      = (state_r == S_RUN);
    assign valid     = (state_r == S_DONE);
    assign quotient  = quotient_r;
    assign remainder = remainder_r;

endmodule

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit
//
// Self-checking bench for div_unit (WIDTH=32). It runs a table of directed
// vectors, then randomized operations checked against an arithmetic
// reference model. Hand-written sequences cover flush, start+flush,
// back-to-back issue, flush in DONE and asynchronous reset mid-run.
// -----------------------------------------------------------------------------
module tb_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic         is_signed = 1'b0;
    logic [W-1:0] dividend = 32'd0;
    logic [W-1:0] divisor = 32'd0;
    logic         busy;
    logic         valid;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;

    int checks = 0;
    int failures = 0;

    div_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .flush     (flush),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .valid     (valid),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         sgn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
    } vec_t;

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic. SystemVerilog / and % truncate
    // toward zero, which matches DIV. -2^31/-1 = 2^31 wraps to 0x80000000.
    task automatic model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r);
        longint sa;
        longint sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (s) begin
            sa = $signed(a);
            sb = $signed(b);
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    // Issue one operation from IDLE. Count edges after the start edge until
    // valid is seen, count busy samples, and check that valid lasts one cycle.
    task automatic do_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output int lat, output int bcnt);
        bit ok;
        @(negedge clk);
        start = 1'b1; is_signed = s; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0;
        ok = 1'b0; lat = 0; bcnt = 0; q = 32'd0; r = 32'd0;
        for (int k = 0; k < 80; k++) begin
            if (busy) bcnt++;
            if (valid) begin
                ok = 1'b1; lat = k; q = quotient; r = remainder;
                break;
            end
            @(posedge clk); #1;
        end
        check("valid_timeout", {31'd0, ok}, 32'd1);
        @(posedge clk); #1;
        check("valid_one_cycle", {31'd0, valid}, 32'd0);
    endtask

    vec_t         vecs[$];
    logic [W-1:0] q, r, eq, er, prev_q, prev_r;
    int           lat, bcnt, vcount;
    logic         s;
    logic [W-1:0] a, b;

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_quotient", quotient, 32'd0);
        check("rst_remainder", remainder, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors
        vecs.push_back('{1'b0, 32'd100,        32'd7,          32'd14,         32'd2});
        vecs.push_back('{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF});
        vecs.push_back('{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1});
        vecs.push_back('{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0});
        vecs.push_back('{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0});
        vecs.push_back('{1'b0, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678});
        vecs.push_back('{1'b1, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF9});
        vecs.push_back('{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE});
        vecs.push_back('{1'b1, 32'h8000_0000,  32'd1,          32'h8000_0000,  32'd0});
        vecs.push_back('{1'b0, 32'hFFFF_FFFF,  32'd2,          32'h7FFF_FFFF,  32'd1});
        vecs.push_back('{1'b0, 32'd5,          32'd7,          32'd0,          32'd5});
        vecs.push_back('{1'b0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1});
        foreach (vecs[i]) begin
            do_op(vecs[i].sgn, vecs[i].a, vecs[i].b, q, r, lat, bcnt);
            check($sformatf("vec%0d_q", i), q, vecs[i].q);
            check($sformatf("vec%0d_r", i), r, vecs[i].r);
            check($sformatf("vec%0d_lat", i), 32'(lat), (vecs[i].b == 32'd0) ? 32'd0 : 32'd32);
            check($sformatf("vec%0d_busy", i), 32'(bcnt), (vecs[i].b == 32'd0) ? 32'd0 : 32'd32);
        end

        // Randomized operations against the model
        for (int n = 0; n < 40; n++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            case ($urandom_range(0, 4))
                0:       b = $urandom;
                1:       b = 32'($urandom_range(1, 20));
                2:       b = -32'($urandom_range(1, 20));
                3:       b = 32'd0;
                default: b = 32'($urandom_range(1, 100000));
            endcase
            model(s, a, b, eq, er);
            do_op(s, a, b, q, r, lat, bcnt);
            check($sformatf("rnd%0d_q", n), q, eq);
            check($sformatf("rnd%0d_r", n), r, er);
            check($sformatf("rnd%0d_lat", n), 32'(lat), (b == 32'd0) ? 32'd0 : 32'd32);
        end

        // Flush at RUN cycle 10: no valid, results keep the previous value
        do_op(1'b0, 32'd100, 32'd7, prev_q, prev_r, lat, bcnt);
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd10;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        vcount = 0;
        for (int k = 0; k < 40; k++) begin
            if (valid) vcount++;
            @(posedge clk); #1;
        end
        check("flush_no_valid", 32'(vcount), 32'd0);
        check("flush_q_hold", quotient, 32'd14);
        check("flush_r_hold", remainder, 32'd2);

        // Start and flush together: request dropped (zero divisor would
        // otherwise produce valid on the very next cycle)
        @(negedge clk);
        start = 1'b1; flush = 1'b1; dividend = 32'h1234_5678; divisor = 32'd0;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        check("sf_valid", {31'd0, valid}, 32'd0);
        check("sf_busy", {31'd0, busy}, 32'd0);
        check("sf_q_hold", quotient, 32'd14);

        // Back-to-back: 100/7, then 50/5 issued in the DONE cycle
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        for (int k = 0; k < 80; k++) begin
            if (valid) begin lat = k; break; end
            @(posedge clk); #1;
        end
        check("b2b_lat1", 32'(lat), 32'd32);
        check("b2b_q1", quotient, 32'd14);
        check("b2b_r1", remainder, 32'd2);
        start = 1'b1; dividend = 32'd50; divisor = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_busy", {31'd0, busy}, 32'd1);
        lat = -1;
        for (int k = 0; k < 80; k++) begin
            if (valid) begin lat = k; break; end
            @(posedge clk); #1;
        end
        check("b2b_lat2", 32'(lat), 32'd32);
        check("b2b_q2", quotient, 32'd10);
        check("b2b_r2", remainder, 32'd0);

        // Flush in DONE with start: valid completes, new request dropped
        start = 1'b1; flush = 1'b1; dividend = 32'd9; divisor = 32'd0;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        check("fdone_valid", {31'd0, valid}, 32'd0);
        check("fdone_busy", {31'd0, busy}, 32'd0);
        check("fdone_q_hold", quotient, 32'd10);

        // Asynchronous reset in the middle of RUN
        @(negedge clk);
        start = 1'b1; dividend = 32'd1000; divisor = 32'd10;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_valid", {31'd0, valid}, 32'd0);
        check("arst_q", quotient, 32'd0);
        check("arst_r", remainder, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        vcount = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (valid || busy) vcount++;
        end
        check("arst_no_activity", 32'(vcount), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
